// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state codes, command bytes and default timing.
package ps2_pkg;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_RTS       = 3'd2;
    localparam logic [2:0] ST_SHIFT     = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    localparam int DEF_INHIBIT_CNT = 2000;
    localparam int DEF_TIMEOUT_CNT = 240000;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins with falling-edge detect on clock.
module ps2_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clk,
    input  logic i_dat,
    output logic o_clk,
    output logic o_dat,
    output logic o_fall
);
    logic r_clk_meta, r_clk_sync, r_clk_prev;
    logic r_dat_meta, r_dat_sync;

    // Reset to the idle (high) bus level so no false edge appears after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= i_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= i_dat;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign o_clk  = r_clk_sync;
    assign o_dat  = r_dat_sync;
    assign o_fall = r_clk_prev & ~r_clk_sync;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, shift on device
// clock falls, ACK check, with a bus timeout covering the device-clocked phases.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CNT = DEF_INHIBIT_CNT,
    parameter int TIMEOUT_CNT = DEF_TIMEOUT_CNT,
    parameter int CW          = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       send,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe
);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CNT - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CNT - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bitidx;
    logic [9:0]    r_shift;
    logic          r_err_pend;

    logic w_clk_s, w_dat_s, w_fall;
    logic w_timed, w_timeout;

    ps2_sync u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clk  (ps2_clk_in),
        .i_dat  (ps2_dat_in),
        .o_clk  (w_clk_s),
        .o_dat  (w_dat_s),
        .o_fall (w_fall)
    );

    assign w_timed   = (r_state == ST_RTS) || (r_state == ST_SHIFT) ||
                       (r_state == ST_ACK) || (r_state == ST_WAIT_IDLE);
    assign w_timeout = w_timed && (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_bitidx   <= '0;
            r_shift    <= '0;
            r_err_pend <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // Timeout wins over any bus event seen in the same cycle.
            if (w_timeout) begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                done       <= 1'b1;
                err        <= 1'b1;
                busy       <= 1'b0;
                r_state    <= ST_IDLE;
            end else begin
                if (w_timed) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                case (r_state)
                    ST_IDLE: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        if (send) begin
                            r_shift    <= {1'b1, odd_parity(data), data};
                            r_err_pend <= 1'b0;
                            busy       <= 1'b1;
                            r_cnt      <= '0;
                            ps2_clk_oe <= 1'b1;
                            r_state    <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (r_cnt == INH_LAST) begin
                            ps2_clk_oe <= 1'b0;
                            ps2_dat_oe <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= ST_RTS;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    ST_RTS: begin
                        if (w_fall) begin
                            ps2_dat_oe <= ~r_shift[0];
                            r_bitidx   <= 4'd1;
                            r_state    <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        // Index 9 is the stop bit (1), which releases the data line.
                        if (w_fall) begin
                            ps2_dat_oe <= ~r_shift[r_bitidx];
                            if (r_bitidx == 4'd9) begin
                                r_state <= ST_ACK;
                            end else begin
                                r_bitidx <= r_bitidx + 4'd1;
                            end
                        end
                    end
                    ST_ACK: begin
                        if (w_fall) begin
                            r_err_pend <= w_dat_s;
                            r_state    <= ST_WAIT_IDLE;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (w_clk_s && w_dat_s) begin
                            done    <= 1'b1;
                            err     <= r_err_pend;
                            busy    <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        ps2_clk_oe <= 1'b0;
                        ps2_dat_oe <= 1'b0;
                        busy       <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with an open-drain bus and a simple keyboard device model.
module tb_ps2_tx;
    localparam int INH  = 20;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic       send = 1'b0;
    logic       busy, done, err;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_in, ps2_dat_in;

    int n_assert = 0;
    int n_fail   = 0;

    assign ps2_clk_in = ~ps2_clk_oe & dev_clk;
    assign ps2_dat_in = ~ps2_dat_oe & dev_dat;

    always #5 clk = ~clk;

    ps2_tx #(.INHIBIT_CNT(INH), .TIMEOUT_CNT(TO), .CW(18)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .send       (send),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ps2_clk_in (ps2_clk_in),
        .ps2_dat_in (ps2_dat_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pulse send and count cycles of clock inhibit; returns at the first RTS cycle.
    task automatic start_tx(input logic [7:0] b, output int inh_cycles);
        @(negedge clk);
        data = b;
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        inh_cycles = 0;
        while (ps2_clk_oe && inh_cycles < 10 * INH) begin
            inh_cycles++;
            @(negedge clk);
        end
    endtask

    // Device clocks n_falls falls; samples data before each rise of falls 1..10.
    task automatic dev_frame(input int n_falls, input bit do_ack, input int send_at,
                             input bit stop_low, output logic [9:0] samp);
        samp = '0;
        for (int k = 1; k <= n_falls; k++) begin
            if (k == 11 && do_ack) begin
                @(negedge clk);
                dev_dat = 1'b0;
                repeat (4) @(negedge clk);
            end
            @(negedge clk);
            dev_clk = 1'b0;
            if (k == n_falls && stop_low) begin
                repeat (6) @(negedge clk);
                return;
            end
            if (k == send_at) begin
                repeat (4) @(negedge clk);
                data = 8'h00;
                send = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
            repeat (HALF) @(negedge clk);
            if (k <= 10) samp[k-1] = ps2_dat_in;
            dev_clk = 1'b1;
            if (k == 11) dev_dat = 1'b1;
            if (k < n_falls) repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic wait_done(output bit got, output logic e, output logic b);
        got = 1'b0;
        e = 1'b0;
        b = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                e = err;
                b = busy;
                break;
            end
        end
    endtask

    initial begin
        int         inh;
        int         n;
        int         extra;
        bit         got;
        logic       e, b;
        logic [9:0] samp;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_dat_oe", ps2_dat_oe, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: 0xED with ACK
        start_tx(8'hED, inh);
        check("ed_inhibit", inh, INH);
        check("ed_start_bit", ps2_dat_oe, 1'b1);
        check("ed_busy", busy, 1'b1);
        dev_frame(11, 1'b1, 0, 1'b0, samp);
        check("ed_bits", samp, 10'h3ED);
        wait_done(got, e, b);
        check("ed_done", got, 1'b1);
        check("ed_err", e, 1'b0);
        check("ed_busy_drop", b, 1'b0);

        // 2: 0x00 and 0x07 (parity 1 and 0), back-to-back
        @(negedge clk);
        start_tx(8'h00, inh);
        dev_frame(11, 1'b1, 0, 1'b0, samp);
        check("b00_bits", samp, 10'h300);
        wait_done(got, e, b);
        check("b00_done", got, 1'b1);
        check("b00_err", e, 1'b0);
        start_tx(8'h07, inh);
        check("b07_inhibit", inh, INH);
        dev_frame(11, 1'b1, 0, 1'b0, samp);
        check("b07_bits", samp, 10'h207);
        wait_done(got, e, b);
        check("b07_done", got, 1'b1);
        check("b07_err", e, 1'b0);

        // 3: no ACK from device
        start_tx(8'hFF, inh);
        dev_frame(11, 1'b0, 0, 1'b0, samp);
        wait_done(got, e, b);
        check("nack_done", got, 1'b1);
        check("nack_err", e, 1'b1);

        // 4: device never clocks -> timeout
        start_tx(8'hED, inh);
        n = 0;
        while (!done && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", n, TO);
        check("to_err", err, 1'b1);
        check("to_busy", busy, 1'b0);
        check("to_clk_oe", ps2_clk_oe, 1'b0);
        check("to_dat_oe", ps2_dat_oe, 1'b0);

        // 5: send pulsed during SHIFT is ignored
        @(negedge clk);
        start_tx(8'hA5, inh);
        dev_frame(11, 1'b1, 5, 1'b0, samp);
        check("busy_send_bits", samp, 10'h3A5);
        wait_done(got, e, b);
        check("busy_send_done", got, 1'b1);
        check("busy_send_err", e, 1'b0);
        extra = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("single_done", extra, 0);
        check("idle_after", busy, 1'b0);

        // 6: async reset at 5th SHIFT fall, then 0xFF completes
        start_tx(8'h00, inh);
        dev_frame(6, 1'b0, 0, 1'b1, samp);
        check("pre_rst_dat_oe", ps2_dat_oe, 1'b1);
        check("pre_rst_busy", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_clk_oe", ps2_clk_oe, 1'b0);
        check("arst_dat_oe", ps2_dat_oe, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        start_tx(8'hFF, inh);
        check("ff_inhibit", inh, INH);
        dev_frame(11, 1'b1, 0, 1'b0, samp);
        check("ff_bits", samp, 10'h3FF);
        wait_done(got, e, b);
        check("ff_done", got, 1'b1);
        check("ff_err", e, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
Name: ps2_tx

Overview:
Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED for the LED update or 0xFF for reset, to the keyboard over the open-drain PS/2 clock and data lines. It performs the inhibit and request-to-send sequence, shifts the frame out on device-generated clock edges, and checks the device ACK bit. It sits beside the keyboard receive path. The keyboard's 0xFA response arrives through the normal receive chain.

Parameters:
INHIBIT_CNT, 2000, system clocks that ps2 clock is held low before request-to-send (must be at least 100 us at the system clock).
TIMEOUT_CNT, 240000, system clocks allowed from request-to-send until the bus returns idle (15 ms at 16 MHz).
CW, 18, width of the shared cycle counter; INHIBIT_CNT and TIMEOUT_CNT must both fit.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
data  in  8  byte to transmit, sampled when send is accepted
send  in  1  start strobe; accepted only in IDLE
busy  out  1  high from the cycle after acceptance until the cycle done pulses
done  out  1  one-cycle pulse at end of transfer, success or failure
err  out  1  one-cycle pulse coincident with done: no ACK or timeout
ps2_clk_in  in  1  raw PS/2 clock pin level
ps2_dat_in  in  1  raw PS/2 data pin level
ps2_clk_oe  out  1  1 = pull PS/2 clock low, 0 = release
ps2_dat_oe  out  1  1 = pull PS/2 data low, 0 = release

Behaviour:
- Reset (rst_n low, async): state IDLE; busy, done, err, ps2_clk_oe and ps2_dat_oe all 0, so both lines are released immediately, including mid-transfer. Counter and bit index are 0.
- Inputs: ps2_clk_in and ps2_dat_in each pass through a 2-FF synchronizer. fall = previous synchronized clock 1 and current 0. All bus decisions use the synchronized values.
- IDLE: outputs released.
  - On send: latch shift register = {1'b1 stop, ~^data odd parity, data}; set busy=1, cnt=0; go to INHIBIT.
  - send in any other state is ignored.
- INHIBIT: ps2_clk_oe=1. Increment cnt each cycle. When cnt reaches INHIBIT_CNT-1: set ps2_dat_oe=1 (start bit), ps2_clk_oe=0, cnt=0; go to RTS. ps2_clk_oe is therefore 1 for exactly INHIBIT_CNT cycles.
- RTS: wait for fall. On fall: drive data bit0 (ps2_dat_oe = ~bit); bitidx=1; go to SHIFT.
- SHIFT: on each fall present the next frame bit, LSB first. Order is data[7:0], then parity, then stop (ps2_dat_oe=0). After the stop bit is presented, go to ACK.
- ACK: on the next fall, sample synchronized data. Low = ACK ok; high = set pending err. Go to WAIT_IDLE.
- WAIT_IDLE: wait until synchronized clock and data are both 1. Then pulse done (and err if pending), clear busy, go to IDLE.
- Timeout: cnt runs continuously from RTS entry. If it reaches TIMEOUT_CNT-1 in RTS, SHIFT, ACK or WAIT_IDLE:
  - release both oe;
  - pulse done and err;
  - busy=0; go to IDLE.
  - Timeout takes priority over a fall in the same cycle.
- Data changes only on falls, so the device samples each bit on the following rising edge.
- State encoding is one-hot or binary (implementer's choice); unused encodings return to IDLE with outputs released.
- Latency: send to ps2_clk_oe rise is 1 cycle. done comes 1 cycle after the idle-bus condition is seen.
- Back-to-back: send asserted in the cycle following done (IDLE) is accepted.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding constants;
  - PS/2 command constants (CMD_SET_LED 8'hED, CMD_RESET 8'hFF, RSP_ACK 8'hFA);
  - default INHIBIT_CNT and TIMEOUT_CNT.
- One sub-module, ps2_sync: 2-FF synchronizer for clock and data, plus falling-edge detect. It is reused by the receive front end.

Test Plan:
1. send data=0xED, device model ACKs.
   - ps2_clk_oe high exactly INHIBIT_CNT cycles, then ps2_dat_oe=1.
   - Device samples 1,0,1,1,0,1,1,1, parity 1, stop 1.
   - done=1, err=0, busy drops the same cycle.
2. send 0x00, then 0x07.
   - Parity bits 1 and 0 respectively; both complete with err=0.
3. Device clocks all 11 bits but leaves data high at the 11th fall.
   - done=1, err=1 after lines go idle.
4. Device never clocks after RTS.
   - At RTS+TIMEOUT_CNT cycles: both oe=0, done=1, err=1, busy=0.
5. send pulsed while busy in SHIFT.
   - Ignored; frame bits unchanged; exactly one done.
6. rst_n low at the 5th fall of SHIFT.
   - Same cycle: ps2_clk_oe=ps2_dat_oe=busy=0, no done.
   - After release, send 0xFF completes normally.
